cirno_encoder: RTL and testbench

Instruction encoder and program writer for the Cirno processing unit. It accepts symbolic instruction requests over a valid/ready handshake, packs each into the 9-bit Cirno instruction word, and writes the words sequentially into instruction memory. It is the writer-side counterpart of the core's instruction decoder and is used by the boot loader and the test harness. It also expands the pseudo-op `LI` (8-bit load-immediate) into a `movih` + `movil` pair.

---
 rtl/cirno_pkg.sv | 57 +++++
 rtl/cirno_enc_pack.sv | 69 ++++++
 rtl/cirno_encoder.sv | 118 +++++++++++
 tb/tb_cirno_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cirno_pkg.sv
// Shared Cirno definitions: opcodes, function codes, field prefixes and
// the encoder FSM state type.
package cirno_pkg;

    localparam int WORD_W = 9;

    typedef enum logic [3:0] {
        OP_NIL   = 4'd0,
        OP_HALT  = 4'd1,
        OP_INCR  = 4'd2,
        OP_JMP   = 4'd3,
        OP_BEQ   = 4'd4,
        OP_BEQI  = 4'd5,
        OP_JMPI  = 4'd6,
        OP_MOVIH = 4'd7,
        OP_MOVIL = 4'd8,
        OP_ANDI  = 4'd9,
        OP_SHLI  = 4'd10,
        OP_SHRI  = 4'd11,
        OP_RR    = 4'd12,
        OP_LI    = 4'd13
    } enc_op_t;

    // ALU / memory function codes carried in RR words
    localparam logic [3:0] FN_LOAD  = 4'b1000;
    localparam logic [3:0] FN_STORE = 4'b1001;
    localparam logic [3:0] FN_MV    = 4'b0111;
    localparam logic [3:0] FN_CMP   = 4'b0110;
    localparam logic [3:0] FN_ANDI  = 4'b0011;
    localparam logic [3:0] FN_SHR   = 4'b0111;
    localparam logic [3:0] FN_SHL   = 4'b1110;

    // Opcode prefixes, identical to the ones the decoder matches on
    localparam logic [2:0] PFX_MOVIL = 3'b100;
    localparam logic [2:0] PFX_MOVIH = 3'b101;
    localparam logic [2:0] PFX_ANDI  = 3'b110;
    localparam logic [2:0] PFX_JMPI  = 3'b111;
    localparam logic [3:0] PFX_SHLI  = 4'b0110;
    localparam logic [3:0] PFX_SHRI  = 4'b0111;
    localparam logic [4:0] PFX_BEQI  = 5'b01011;
    localparam logic [4:0] PFX_SYS   = 5'b00000;
    localparam logic [1:0] SUB_BEQ   = 2'b01;
    localparam logic [1:0] SUB_JMP   = 2'b10;
    localparam logic [1:0] SUB_INCR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT2 = 2'd1,
        S_FULL  = 2'd2
    } enc_state_t;

    // 0000 and 1011 alias system/BEQI words, 11xx aliases the shift space
    function automatic logic funct_legal(input logic [3:0] f);
        return !((f == 4'b0000) || (f == 4'b1011) || (f[3:2] == 2'b11));
    endfunction

endpackage

// File: rtl/cirno_enc_pack.sv
// Combinational field packing and legality check for one request.
module cirno_enc_pack
    import cirno_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [1:0]        r1,
    input  logic [1:0]        r2,
    input  logic [3:0]        funct,
    input  logic [7:0]        imm,
    output logic [WORD_W-1:0] word0,
    output logic [WORD_W-1:0] word1,
    output logic              two_words,
    output logic              illegal
);

    // Build the word(s) for the requested op and flag out-of-range fields
    always_comb begin
        word0     = '0;
        word1     = '0;
        two_words = 1'b0;
        illegal   = 1'b0;
        case (op)
            OP_NIL:   word0 = 9'h000;
            OP_HALT:  word0 = 9'h001;
            OP_INCR:  word0 = {PFX_SYS, SUB_INCR, r1};
            OP_JMP:   word0 = {PFX_SYS, SUB_JMP, r1};
            OP_BEQ:   word0 = {PFX_SYS, SUB_BEQ, r1};
            OP_BEQI: begin
                word0   = {PFX_BEQI, imm[3:0]};
                illegal = |imm[7:4];
            end
            OP_JMPI: begin
                word0   = {PFX_JMPI, imm[5:0]};
                illegal = |imm[7:6];
            end
            OP_MOVIH: begin
                word0   = {PFX_MOVIH, r1, imm[3:0]};
                illegal = |imm[7:4];
            end
            OP_MOVIL: begin
                word0   = {PFX_MOVIL, r1, imm[3:0]};
                illegal = |imm[7:4];
            end
            OP_ANDI: begin
                word0   = {PFX_ANDI, r1, imm[3:0]};
                illegal = |imm[7:4];
            end
            OP_SHLI: begin
                word0   = {PFX_SHLI, r1, imm[2:0]};
                illegal = |imm[7:3];
            end
            OP_SHRI: begin
                word0   = {PFX_SHRI, r1, imm[2:0]};
                illegal = |imm[7:3];
            end
            OP_RR: begin
                word0   = {1'b0, funct, r1, r2};
                illegal = !funct_legal(funct);
            end
            OP_LI: begin
                word0     = {PFX_MOVIH, r1, imm[7:4]};
                word1     = {PFX_MOVIL, r1, imm[3:0]};
                two_words = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cirno_encoder.sv
// Cirno program writer: accepts symbolic requests, writes packed words
// sequentially into instruction memory, expands LI into MOVIH + MOVIL.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | ready for a request
//   S_EMIT2 | MOVIH of an LI written, MOVIL goes out now
//   S_FULL  | last address written, waits for start
module cirno_encoder
    import cirno_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [1:0]        req_r1,
    input  logic [1:0]        req_r2,
    input  logic [3:0]        req_funct,
    input  logic [7:0]        req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              err,
    output logic              full
);

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    enc_state_t        state;
    logic [ADDR_W-1:0] ptr;
    logic [WORD_W-1:0] pend_word;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic              two_words;
    logic              illegal;

    cirno_enc_pack u_pack (
        .op        (req_op),
        .r1        (req_r1),
        .r2        (req_r2),
        .funct     (req_funct),
        .imm       (req_imm),
        .word0     (word0),
        .word1     (word1),
        .two_words (two_words),
        .illegal   (illegal)
    );

    assign req_ready = (state == S_IDLE) && !start;

    // Sequencer: write pointer, pending MOVIL, sticky flags, registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            pend_word <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state    <= S_IDLE;
                ptr      <= '0;
                mem_addr <= '0;
                err      <= 1'b0;
                full     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_valid) begin
                            // an LI at the last address has no room for its MOVIL
                            if (illegal || (two_words && (ptr == LAST))) begin
                                err <= 1'b1;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= ptr;
                                mem_wdata <= word0;
                                if (ptr == LAST) begin
                                    full  <= 1'b1;
                                    state <= S_FULL;
                                end else begin
                                    ptr <= ptr + ONE;
                                    if (two_words) begin
                                        pend_word <= word1;
                                        state     <= S_EMIT2;
                                    end
                                end
                            end
                        end
                    end
                    S_EMIT2: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= pend_word;
                        if (ptr == LAST) begin
                            full  <= 1'b1;
                            state <= S_FULL;
                        end else begin
                            ptr   <= ptr + ONE;
                            state <= S_IDLE;
                        end
                    end
                    S_FULL:  state <= S_FULL;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cirno_encoder.sv
// Self-checking bench for cirno_encoder: directed cases plus random traffic
// against a cycle-level behavioural model of the program writer.
module tb_cirno_encoder;

    localparam int AW    = 4;
    localparam int LASTA = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [1:0]    req_r1;
    logic [1:0]    req_r2;
    logic [3:0]    req_funct;
    logic [7:0]    req_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [8:0]    mem_wdata;
    logic          err;
    logic          full;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_addr;
    bit m_err;
    bit m_full;
    bit m_pend;
    int m_pend_w;

    cirno_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_r1    (req_r1),
        .req_r2    (req_r2),
        .req_funct (req_funct),
        .req_imm   (req_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err       (err),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_legal(input int op, input int fn, input int imm);
        case (op)
            5, 7, 8, 9: return imm <= 15;
            6:          return imm <= 63;
            10, 11:     return imm <= 7;
            12:         return (fn != 0) && (fn != 11) && (fn < 12);
            14, 15:     return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int m_word(input int op, input int r1, input int r2, input int fn, input int imm);
        case (op)
            0:  return 'h000;
            1:  return 'h001;
            2:  return 'h00C + r1;
            3:  return 'h008 + r1;
            4:  return 'h004 + r1;
            5:  return 'h0B0 + imm;
            6:  return 'h1C0 + imm;
            7:  return 'h140 + r1 * 16 + imm;
            8:  return 'h100 + r1 * 16 + imm;
            9:  return 'h180 + r1 * 16 + imm;
            10: return 'h0C0 + r1 * 8 + imm;
            11: return 'h0E0 + r1 * 8 + imm;
            12: return fn * 16 + r1 * 4 + r2;
            default: return 0;
        endcase
    endfunction

    task automatic m_bump();
        if (m_addr == LASTA) m_full = 1'b1;
        else m_addr++;
    endtask

    task automatic m_reset();
        m_addr = 0; m_err = 0; m_full = 0; m_pend = 0; m_pend_w = 0;
    endtask

    // one clock: drive, check ready, advance model, check registered outputs
    task automatic step(input bit st, input bit v, input int op, input int r1,
                        input int r2, input int fn, input int imm);
        bit e_ready;
        bit e_we;
        int e_addr;
        int e_wd;
        start = st; req_valid = v; req_op = 4'(op); req_r1 = 2'(r1);
        req_r2 = 2'(r2); req_funct = 4'(fn); req_imm = 8'(imm);
        #1;
        e_ready = !m_pend && !m_full && !st;
        chk("ready", 32'(req_ready), 32'(e_ready));
        e_we = 0; e_addr = 0; e_wd = 0;
        if (st) begin
            m_pend = 0; m_addr = 0; m_err = 0; m_full = 0;
        end else if (m_pend) begin
            e_we = 1; e_addr = m_addr; e_wd = m_pend_w; m_pend = 0;
            m_bump();
        end else if (!m_full && v) begin
            if (!m_legal(op, fn, imm) || (op == 13 && m_addr == LASTA)) begin
                m_err = 1;
            end else begin
                e_we = 1; e_addr = m_addr;
                if (op == 13) begin
                    e_wd = 'h140 + r1 * 16 + imm / 16;
                    m_pend = 1;
                    m_pend_w = 'h100 + r1 * 16 + imm % 16;
                end else begin
                    e_wd = m_word(op, r1, r2, fn, imm);
                end
                m_bump();
            end
        end
        @(posedge clk);
        #1;
        chk("we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
            chk("addr", 32'(mem_addr), 32'(e_addr));
            chk("wdata", 32'(mem_wdata), 32'(e_wd));
        end
        if (st) chk("addr_start", 32'(mem_addr), 32'd0);
        chk("err", 32'(err), 32'(m_err));
        chk("full", 32'(full), 32'(m_full));
        req_valid = 0; start = 0;
    endtask

    task automatic req(input int op, input int r1, input int r2, input int fn, input int imm);
        step(0, 1, op, r1, r2, fn, imm);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; req_valid = 0; req_op = 0; req_r1 = 0;
        req_r2 = 0; req_funct = 0; req_imm = 0;
        m_reset();
        @(posedge clk); #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst_n = 1;
        idle();

        req(6, 0, 0, 0, 'h2A);
        chk("jmpi_word", 32'(mem_wdata), 32'h1EA);
        chk("jmpi_addr", 32'(mem_addr), 32'd0);

        step(1, 0, 0, 0, 0, 0, 0);
        req(13, 2, 0, 0, 'hA5);
        chk("li_hi", 32'(mem_wdata), 32'h16A);
        idle();
        chk("li_lo", 32'(mem_wdata), 32'h125);
        chk("li_lo_addr", 32'(mem_addr), 32'd1);

        req(11, 1, 0, 0, 5);
        chk("shri_word", 32'(mem_wdata), 32'h0ED);
        req(11, 1, 0, 0, 9);
        req(0, 0, 0, 0, 0);
        chk("after_err_addr", 32'(mem_addr), 32'd3);
        req(12, 3, 0, 'b1001, 0);
        chk("rr_word", 32'(mem_wdata), 32'h09C);
        req(12, 3, 0, 'b1011, 0);
        req(1, 0, 0, 0, 0);
        chk("halt_word", 32'(mem_wdata), 32'h001);
        req(14, 0, 0, 0, 0);
        req(15, 0, 0, 0, 0);

        // fill to the last address, LI with one word left must be refused
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LASTA; i++) req(0, 0, 0, 0, 0);
        req(13, 1, 0, 0, 'h33);
        req(0, 0, 0, 0, 0);
        chk("full_flag", 32'(full), 32'd1);
        req(1, 0, 0, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0);
        req(0, 0, 0, 0, 0);

        // LI ending exactly on the last address
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LASTA - 1; i++) req(2, i % 4, 0, 0, 0);
        req(13, 3, 0, 0, 'h7E);
        idle();
        idle();

        // start during EMIT2 drops the MOVIL
        step(1, 0, 0, 0, 0, 0, 0);
        req(13, 1, 0, 0, 'h9C);
        step(1, 1, 0, 0, 0, 0, 0);
        req(9, 2, 0, 0, 6);

        // reset between the two LI words
        req(14, 0, 0, 0, 0);
        req(13, 1, 0, 0, 'h3C);
        #2 rst_n = 0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_wdata", 32'(mem_wdata), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        m_reset();
        @(posedge clk); #1;
        chk("arst_nomovil", 32'(mem_we), 32'd0);
        rst_n = 1;
        req(0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            int imm;
            imm = ($urandom % 2 == 0) ? int'($urandom % 8) : int'($urandom % 256);
            step(($urandom % 40) == 0, ($urandom % 4) != 0, int'($urandom % 16),
                 int'($urandom % 4), int'($urandom % 4), int'($urandom % 16), imm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
